// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_uart_tx : pops words from a synchronous FIFO and sends UART frames
// Revision     : 1.0
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t                r_state, w_state_n;
  logic [BAUD_W-1:0]     r_baud, w_baud_n;
  logic [BIT_W-1:0]      r_bit, w_bit_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n, w_shifted;
  logic                  r_parity, w_parity_n;
  logic                  w_tx_n, w_read_en_n, w_busy_n, w_done_n;
  logic                  w_baud_last;

  assign w_baud_last = (r_baud == C_BAUD_LAST);
  assign w_shifted   = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      tx           <= 1'b1;
      fifo_read_en <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_baud       <= w_baud_n;
      r_bit        <= w_bit_n;
      r_shift      <= w_shift_n;
      r_parity     <= w_parity_n;
      tx           <= w_tx_n;
      fifo_read_en <= w_read_en_n;
      busy         <= w_busy_n;
      frame_done   <= w_done_n;
    end
  end

  // Next-state logic also computes the registered output values, so every
  // output changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_n   = r_state;
    w_baud_n    = r_baud;
    w_bit_n     = r_bit;
    w_shift_n   = r_shift;
    w_parity_n  = r_parity;
    w_tx_n      = tx;
    w_read_en_n = 1'b0;
    w_busy_n    = busy;
    w_done_n    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        if (!fifo_empty) begin
          w_state_n   = S_POP;
          w_read_en_n = 1'b1;
          w_busy_n    = 1'b1;
        end
      end
      S_POP: begin
        w_state_n = S_LOAD;
      end
      S_LOAD: begin
        // FIFO read data is valid here, one cycle after the pop
        w_shift_n  = fifo_data;
        w_parity_n = ^fifo_data;
        w_state_n  = S_START;
        w_tx_n     = 1'b0;
        w_baud_n   = '0;
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_n  = '0;
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_n  = '0;
          w_shift_n = w_shifted;
          if (r_bit == C_BIT_LAST) begin
            w_bit_n = '0;
            if (PARITY_EN != 0) begin
              w_state_n = S_PARITY;
              w_tx_n    = r_parity;
            end else begin
              w_state_n = S_STOP;
              w_tx_n    = 1'b1;
            end
          end else begin
            w_bit_n = r_bit + BIT_W'(1);
            w_tx_n  = w_shifted[0];
          end
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (w_baud_last) begin
          w_baud_n  = '0;
          w_state_n = S_STOP;
          w_tx_n    = 1'b1;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_n  = '0;
          w_state_n = S_IDLE;
          w_tx_n    = 1'b1;
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
        end else begin
          w_baud_n = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx : directed bench, three DUT configurations fed by FIFO models
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int LOG = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] tx_w, re_w, busy_w, done_w, empty_w;
  logic [7:0] fdata [3];
  logic [7:0] mem [3][16];
  int         wp [3];
  int         rp [3];
  int         pop_err [3];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic tx_l [3][LOG];
  logic re_l [3][LOG];
  logic bz_l [3][LOG];
  logic dn_l [3][LOG];

  always #5 clk = ~clk;

  // inst 0: C=4 no parity, inst 1: C=4 even parity, inst 2: C=2 no parity
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(empty_w[0]), .fifo_data(fdata[0]),
    .fifo_read_en(re_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(empty_w[1]), .fifo_data(fdata[1]),
    .fifo_read_en(re_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(0)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(empty_w[2]), .fifo_data(fdata[2]),
    .fifo_read_en(re_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

  always_comb begin
    for (int i = 0; i < 3; i++) empty_w[i] = (wp[i] == rp[i]);
  end

  // Registered-read FIFO model: data valid the cycle after read_en is sampled
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (re_w[i]) begin
        if (wp[i] == rp[i]) pop_err[i] <= pop_err[i] + 1;
        else begin
          fdata[i] <= mem[i][rp[i]];
          rp[i]    <= rp[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cyc < LOG) begin
      for (int i = 0; i < 3; i++) begin
        tx_l[i][cyc] = tx_w[i];
        re_l[i][cyc] = re_w[i];
        bz_l[i][cyc] = busy_w[i];
        dn_l[i][cyc] = done_w[i];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic lg(input int sel, input int i, input int k);
    if (k < 0 || k >= LOG) return 1'b0;
    case (sel)
      0: return tx_l[i][k];
      1: return re_l[i][k];
      2: return bz_l[i][k];
      default: return dn_l[i][k];
    endcase
  endfunction

  function automatic int cnt(input int sel, input int i, input int from, input int to);
    int n = 0;
    for (int k = from; k <= to; k++) if (lg(sel, i, k) === 1'b1) n++;
    return n;
  endfunction

  function automatic int find_re(input int i, input int from);
    for (int k = from; k < LOG; k++) if (re_l[i][k] === 1'b1) return k;
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] d);
    mem[i][wp[i]] = d;
    wp[i] = wp[i] + 1;
  endtask

  // pat lists the frame bits in line order, p is the sample holding the pop
  task automatic frame_check(input int i, input int p, input string pat,
                             input int c, input string tag);
    int n, e;
    logic [63:0] got, exp;
    if (p < 0) begin
      check({tag, "_pop_found"}, 64'd0, 64'd1);
      return;
    end
    n = pat.len() * c;
    e = p + 2 + n;
    got = '0;
    exp = '0;
    for (int j = 0; j < n; j++) begin
      got[j] = lg(0, i, p + 2 + j);
      exp[j] = (pat[j / c] == 8'h31);
    end
    check({tag, "_tx"}, got, exp);
    check({tag, "_pre_tx"}, {62'd0, lg(0, i, p), lg(0, i, p + 1)}, 64'd3);
    check({tag, "_re_pulse"}, {62'd0, lg(1, i, p), lg(1, i, p + 1)}, 64'd2);
    check({tag, "_done_at_end"}, {62'd0, lg(3, i, e), lg(3, i, e + 1)}, 64'd2);
    check({tag, "_done_early"}, 64'(cnt(3, i, p, e - 1)), 64'd0);
    check({tag, "_busy_cnt"}, 64'(cnt(2, i, p, e - 1)), 64'(n + 2));
    check({tag, "_busy_edges"}, {62'd0, lg(2, i, p - 1), lg(2, i, e)}, 64'd0);
  endtask

  initial begin : stim
    int t1s, t1e, b2, b4, b5, p5, p, pn;
    logic found;
    string pats [4];
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0;
      rp[i] = 0;
      pop_err[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t1s = cyc;
    repeat (50) @(negedge clk);
    t1e = cyc;

    push(0, 8'hA5);
    push(1, 8'h07);
    push(2, 8'h12); push(2, 8'h34); push(2, 8'hC3); push(2, 8'h5A);
    b2 = cyc;
    repeat (150) @(negedge clk);

    push(0, 8'h00); push(0, 8'hFF);
    b4 = cyc;
    repeat (120) @(negedge clk);

    push(0, 8'h3C); push(0, 8'h81);
    b5 = cyc;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (re_w[0] === 1'b1) found = 1'b1;
    end
    p5 = cyc;
    check("t5_pop_seen", 64'(found), 64'd1);
    repeat (19) @(negedge clk);
    reset = 1'b1;       // edge p5+20 falls in the middle of data bit 3
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);

    // reset state and idle with empty FIFO
    check("reset_state", {60'd0, lg(0, 0, 2), lg(1, 0, 2), lg(2, 0, 2), lg(3, 0, 2)}, 64'h8);
    for (int i = 0; i < 3; i++) begin
      check("t1_tx_low", 64'(cnt(0, i, t1s, t1e) - (t1e - t1s + 1)), 64'd0);
      check("t1_re", 64'(cnt(1, i, t1s, t1e)), 64'd0);
      check("t1_busy", 64'(cnt(2, i, t1s, t1e)), 64'd0);
    end

    frame_check(0, find_re(0, b2), "0101001011", 4, "t2_a5");
    frame_check(1, find_re(1, b2), "01110000011", 4, "t3_07par");

    p = find_re(0, b4);
    frame_check(0, p, "0000000001", 4, "t4_00");
    pn = find_re(0, p + 1);
    check("t4_gap", 64'(pn - p), 64'd43);
    frame_check(0, pn, "0111111111", 4, "t4_ff");
    check("t4_pops", 64'(cnt(1, 0, b4, b5 - 1)), 64'd2);
    check("t4_dones", 64'(cnt(3, 0, b4, b5 - 1)), 64'd2);

    begin : t5
      logic [63:0] got;
      got = '0;
      for (int j = 0; j < 18; j++) got[j] = lg(0, 0, p5 + 2 + j);
      check("t5_tx_before_reset", got, 64'h3F000);
    end
    check("t5_after_reset", {62'd0, lg(0, 0, p5 + 20), lg(2, 0, p5 + 20)}, 64'd2);
    check("t5_no_done", 64'(cnt(3, 0, p5, p5 + 21)), 64'd0);
    check("t5_next_pop", 64'(find_re(0, p5 + 1)), 64'(p5 + 21));
    frame_check(0, p5 + 21, "0100000011", 4, "t5_81");

    pats[0] = "0010010001";
    pats[1] = "0001011001";
    pats[2] = "0110000111";
    pats[3] = "0010110101";
    p = find_re(2, b2);
    for (int w = 0; w < 4; w++) begin
      frame_check(2, p, pats[w], 2, $sformatf("t6_w%0d", w));
      pn = find_re(2, (p < 0) ? LOG : p + 1);
      if (w < 3) check($sformatf("t6_gap%0d", w), 64'(pn - p), 64'd23);
      p = pn;
    end

    check("tot_pops0", 64'(cnt(1, 0, 0, LOG - 1)), 64'd5);
    check("tot_dones0", 64'(cnt(3, 0, 0, LOG - 1)), 64'd4);
    check("tot_pops1", 64'(cnt(1, 1, 0, LOG - 1)), 64'd1);
    check("tot_dones1", 64'(cnt(3, 1, 0, LOG - 1)), 64'd1);
    check("tot_pops2", 64'(cnt(1, 2, 0, LOG - 1)), 64'd4);
    check("tot_dones2", 64'(cnt(3, 2, 0, LOG - 1)), 64'd4);
    for (int i = 0; i < 3; i++) check("pop_when_empty", 64'(pop_err[i]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
